// File: rtl/sc_reggeneral_arbiter_if.sv
// rtl/sc_reggeneral_arbiter_if.sv - requester/register-side signal bundle for the general register arbiter
interface sc_reggeneral_arbiter_if #(
    parameter int DATAWIDTH = 8
);
    logic [1:0]             SC_RegGENARB_req_InHigh;
    logic [DATAWIDTH-1:0]   SC_RegGENARB_data0_InBUS;
    logic [DATAWIDTH-1:0]   SC_RegGENARB_data1_InBUS;
    logic                   SC_RegGENARB_clrreq_InHigh;
    logic [1:0]             SC_RegGENARB_ack_OutHigh;
    logic                   SC_RegGENARB_clrack_OutHigh;
    logic [1:0]             SC_RegGENARB_grant_OutHigh;
    logic                   SC_RegGENARB_busy_OutHigh;
    logic                   SC_RegGENARB_clear_OutHigh;
    logic                   SC_RegGENARB_load_OutLow;
    logic [DATAWIDTH/2-1:0] SC_RegGENARB_data_OutBUS1;
    logic [DATAWIDTH/2-1:0] SC_RegGENARB_data_OutBUS2;

    modport master (
        output SC_RegGENARB_req_InHigh,
        output SC_RegGENARB_data0_InBUS,
        output SC_RegGENARB_data1_InBUS,
        output SC_RegGENARB_clrreq_InHigh,
        input  SC_RegGENARB_ack_OutHigh,
        input  SC_RegGENARB_clrack_OutHigh,
        input  SC_RegGENARB_grant_OutHigh,
        input  SC_RegGENARB_busy_OutHigh,
        input  SC_RegGENARB_clear_OutHigh,
        input  SC_RegGENARB_load_OutLow,
        input  SC_RegGENARB_data_OutBUS1,
        input  SC_RegGENARB_data_OutBUS2
    );

    modport slave (
        input  SC_RegGENARB_req_InHigh,
        input  SC_RegGENARB_data0_InBUS,
        input  SC_RegGENARB_data1_InBUS,
        input  SC_RegGENARB_clrreq_InHigh,
        output SC_RegGENARB_ack_OutHigh,
        output SC_RegGENARB_clrack_OutHigh,
        output SC_RegGENARB_grant_OutHigh,
        output SC_RegGENARB_busy_OutHigh,
        output SC_RegGENARB_clear_OutHigh,
        output SC_RegGENARB_load_OutLow,
        output SC_RegGENARB_data_OutBUS1,
        output SC_RegGENARB_data_OutBUS2
    );
endinterface

// File: rtl/sc_reggeneral_arbiter.sv
// rtl/sc_reggeneral_arbiter.sv - two-requester load/clear sequencer for the split-bus general register
// Optional macro SC_REGGENARB_FIXED_PRIORITY_EN: requester 0 always wins ties instead of round-robin.
module sc_reggeneral_arbiter #(
    parameter int DATAWIDTH   = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   SC_RegGENARB_CLOCK_50,
    input  logic                   SC_RegGENARB_RESET_InLow,
    sc_reggeneral_arbiter_if.slave arb
);
    localparam int HALF = DATAWIDTH / 2;
    localparam int CW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, HOLD} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      grant, grant_nxt;
    logic [1:0]      ack, ack_nxt;
    logic            clrack, clrack_nxt;
    logic            busy, busy_nxt;
    logic            clear, clear_nxt;
    logic            load_n, load_n_nxt;
    logic [HALF-1:0] bus1, bus1_nxt;
    logic [HALF-1:0] bus2, bus2_nxt;
    logic            win1;
    logic [DATAWIDTH-1:0] win_word;

`ifdef SC_REGGENARB_FIXED_PRIORITY_EN
    assign win1 = arb.SC_RegGENARB_req_InHigh[1] & ~arb.SC_RegGENARB_req_InHigh[0];
`else
    // rr_ptr names the requester preferred on the next tie
    logic rr_ptr;
    assign win1 = arb.SC_RegGENARB_req_InHigh[1] &
                  (~arb.SC_RegGENARB_req_InHigh[0] | rr_ptr);

    always_ff @(posedge SC_RegGENARB_CLOCK_50) begin
        if (!SC_RegGENARB_RESET_InLow) begin
            rr_ptr <= 1'b0;
        end else if (state == LOAD) begin
            rr_ptr <= grant[0];
        end
    end
`endif

    assign win_word = win1 ? arb.SC_RegGENARB_data1_InBUS : arb.SC_RegGENARB_data0_InBUS;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        grant_nxt  = grant;
        ack_nxt    = 2'b00;
        clrack_nxt = 1'b0;
        clear_nxt  = 1'b0;
        load_n_nxt = 1'b1;
        bus1_nxt   = bus1;
        bus2_nxt   = bus2;
        case (state)
            IDLE: begin
                if (arb.SC_RegGENARB_clrreq_InHigh) begin
                    state_nxt = CLEAR;
                    clear_nxt = 1'b1;
                end else if (|arb.SC_RegGENARB_req_InHigh) begin
                    state_nxt  = LOAD;
                    load_n_nxt = 1'b0;
                    grant_nxt  = win1 ? 2'b10 : 2'b01;
                    bus1_nxt   = win_word[DATAWIDTH-1:HALF];
                    bus2_nxt   = win_word[HALF-1:0];
                end
            end
            CLEAR: begin
                state_nxt  = HOLD;
                clrack_nxt = 1'b1;
                cnt_nxt    = HOLD_INIT;
            end
            LOAD: begin
                state_nxt = HOLD;
                ack_nxt   = grant;
                cnt_nxt   = HOLD_INIT;
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    grant_nxt = 2'b00;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Outputs are registered from the next-state view so they align with the state they describe
    always_ff @(posedge SC_RegGENARB_CLOCK_50) begin
        if (!SC_RegGENARB_RESET_InLow) begin
            state  <= IDLE;
            cnt    <= '0;
            grant  <= 2'b00;
            ack    <= 2'b00;
            clrack <= 1'b0;
            busy   <= 1'b0;
            clear  <= 1'b0;
            load_n <= 1'b1;
            bus1   <= '0;
            bus2   <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            grant  <= grant_nxt;
            ack    <= ack_nxt;
            clrack <= clrack_nxt;
            busy   <= busy_nxt;
            clear  <= clear_nxt;
            load_n <= load_n_nxt;
            bus1   <= bus1_nxt;
            bus2   <= bus2_nxt;
        end
    end

    assign arb.SC_RegGENARB_ack_OutHigh    = ack;
    assign arb.SC_RegGENARB_clrack_OutHigh = clrack;
    assign arb.SC_RegGENARB_grant_OutHigh  = grant;
    assign arb.SC_RegGENARB_busy_OutHigh   = busy;
    assign arb.SC_RegGENARB_clear_OutHigh  = clear;
    assign arb.SC_RegGENARB_load_OutLow    = load_n;
    assign arb.SC_RegGENARB_data_OutBUS1   = bus1;
    assign arb.SC_RegGENARB_data_OutBUS2   = bus2;
endmodule
